eeprom_i2c_master: RTL and testbench
====================================

Name: eeprom_i2c_master

Overview:
- Hardware byte-level I2C initiator for the cartridge serial EEPROM. It replaces CPU bit-banging of the GPIO pins that drive EEPROM clock and data.
- Accepts START / STOP / WRITE-byte / READ-byte commands through a valid/ready handshake and generates SCL/SDA open-drain waveforms.
- Returns one response per byte command.
- Sits between a future register front-end in the minx top and the EEPROM pins.

Parameters:
- CLK_DIV, 4: clk cycles per quarter SCL period (minimum 2). One SCL bit = 4*CLK_DIV cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  engine can accept a command this cycle
- cmd  input  2  00=START (also repeated start), 01=STOP, 10=WRITE, 11=READ
- cmd_data  input  8  byte to transmit (WRITE)
- cmd_nack  input  1  READ only: master ack bit to send (0=ACK, 1=NACK)
- rsp_valid  output  1  one-cycle response pulse
- rsp_data  output  8  received byte (READ); 0 for WRITE
- rsp_nack  output  1  WRITE: sampled slave ack bit (1=NACK); READ: echo of cmd_nack
- rsp_err  output  1  command illegal in current bus state
- busy  output  1  bus owned (after START, before STOP completes)
- scl_out  output  1  1=release SCL, 0=drive low
- sda_out  output  1  1=release SDA, 0=drive low
- scl_in  input  1  sampled SCL pin (clock stretching)
- sda_in  input  1  sampled SDA pin

Behaviour:
- Reset (async, active low):
  - scl_out=1, sda_out=1, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_nack=0, rsp_err=0, busy=0.
  - State FREE; counters cleared.
  - Reset mid-transfer releases both lines immediately. No STOP is generated.
- States: FREE, HELD (bus owned, SCL low), START_SEQ, STOP_SEQ, BYTE_SEQ.
  - cmd_ready=1 only in FREE and HELD.
  - A command is accepted on cmd_valid&&cmd_ready; cmd_ready drops the next cycle.
  - cmd_data and cmd_nack are latched at acceptance.
- Quarter timer:
  - Counts CLK_DIV cycles per quarter q0..q3.
  - In any quarter where scl_out=1, the timer holds while scl_in=0 (clock stretching, unbounded).
- START_SEQ (from FREE or HELD):
  - q0: SCL0 SDA1
  - q1: SCL1 SDA1
  - q2: SCL1 SDA0
  - q3: SCL0 SDA0
  - Then HELD, busy=1. No response.
- STOP_SEQ (from HELD):
  - q0: SCL0 SDA0
  - q1: SCL1 SDA0
  - q2: SCL1 SDA1
  - q3: SCL1 SDA1
  - Then FREE, busy=0. No response.
- BYTE_SEQ: 9 bit slots, MSB first, 8 data slots then 1 ack slot.
  - Each slot: q0 SCL0 with SDA set at the start of q0; q1 SCL0; q2 SCL1; q3 SCL1.
  - sda_in is sampled on the last cycle of q3.
  - WRITE: SDA = data bits, then release for the ack slot. The ack sample goes to rsp_nack.
  - READ: SDA released for 8 slots and samples are shifted into rsp_data. The ack slot drives cmd_nack.
  - After slot 8 q3, the engine drives SCL0 and returns to HELD. rsp_valid pulses the same cycle HELD is entered.
  - Byte latency, no stretching: 36*CLK_DIV cycles from acceptance to rsp_valid.
- Illegal commands:
  - WRITE/READ in FREE: no bus activity. rsp_valid with rsp_err=1, rsp_data=0, rsp_nack=1 on the cycle after acceptance.
  - STOP in FREE: no bus activity, no response. cmd_ready returns the next cycle.
- rsp_* values hold until the next response. rsp_err clears on the next legal response.
- SDA changes only while scl_out=0, except the START/STOP edges above.
- No multi-master arbitration: sda_in mismatch during WRITE is ignored.

Test Plan:
- CLK_DIV=4, START then WRITE 0xA0, slave acks:
  - START takes 16 cycles; SDA falls while SCL high.
  - SDA slot values 1,0,1,0,0,0,0,0 then released.
  - rsp_valid exactly 144 cycles after WRITE acceptance, rsp_nack=0, rsp_data=0.
- WRITE with no slave present (sda_in stays 1) -> rsp_nack=1; busy stays 1 and state is HELD.
- READ with slave driving 0x5C, cmd_nack=1 -> rsp_data=0x5C, rsp_nack=1. SDA released for 8 slots, driven high (released) in the ack slot.
- Repeated START from HELD then STOP -> SDA rises while SCL high in STOP q2; busy falls after q3; scl_out=sda_out=1.
- WRITE in FREE -> rsp_err=1 one cycle after acceptance, no SCL/SDA toggles. STOP in FREE -> no response, cmd_ready back after 1 cycle.
- Clock stretching and reset:
  - Hold scl_in=0 for 20 cycles in slot 3 q2 -> rsp_valid delayed by exactly 20 cycles.
  - Assert reset mid-byte -> lines released and outputs at reset values asynchronously.

Source files
------------

// File: rtl/eeprom_i2c_master.sv
// -----------------------------------------------------------------------------
// eeprom_i2c_master
//   Byte-level I2C initiator for the cartridge serial EEPROM. A small command
//   engine generates the open-drain SCL/SDA waveforms. It takes START, STOP,
//   WRITE-byte and READ-byte commands through a valid/ready handshake. Each
//   byte command (or illegal command) produces one response pulse.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   cmd_valid  command offered           cmd_ready  engine can accept
//   cmd        00 START, 01 STOP, 10 WRITE, 11 READ
//   cmd_data   byte to transmit (WRITE)  cmd_nack   master ack bit (READ)
//   rsp_valid  one-cycle response pulse  rsp_data   received byte (READ)
//   rsp_nack   slave ack (WRITE) / echo of cmd_nack (READ)
//   rsp_err    command illegal in current bus state
//   busy       bus owned (START done, STOP not yet finished)
//   scl_out    1 = release SCL, 0 = drive low
//   sda_out    1 = release SDA, 0 = drive low
//   scl_in     sampled SCL pin (used for clock stretching)
//   sda_in     sampled SDA pin
// -----------------------------------------------------------------------------
module eeprom_i2c_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] cmd_data,
   input  logic       cmd_nack,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_nack,
   output logic       rsp_err,
   output logic       busy,
   output logic       scl_out,
   output logic       sda_out,
   input  logic       scl_in,
   input  logic       sda_in
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_STOP  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_READ  = 2'b11;

   // ST_WAIT is a one-cycle turnaround used after commands rejected in FREE,
   // so cmd_ready drops for one cycle like after any other acceptance.
   typedef enum logic [2:0] {
      ST_FREE,
      ST_HELD,
      ST_START,
      ST_STOP,
      ST_BYTE,
      ST_WAIT
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      qtr_q, qtr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      slot_q, slot_d;
   logic [7:0]      tx_q, tx_d;
   logic [7:0]      rx_q, rx_d;
   logic            read_q, read_d;
   logic            nack_q, nack_d;
   logic            busy_q, busy_d;
   logic            scl_q, scl_d;
   logic            sda_q, sda_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic            rsp_nack_q, rsp_nack_d;
   logic            rsp_err_q, rsp_err_d;

   logic            accept;
   logic            tick;
   logic            qend;
   logic            seq_done;

   assign cmd_ready = (state_q == ST_FREE) || (state_q == ST_HELD);
   assign accept    = cmd_valid && cmd_ready;

   // Timer only advances while SCL is driven low or the pin has actually
   // gone high; a slave holding SCL low freezes the current quarter.
   assign tick     = !scl_q || scl_in;
   assign qend     = tick && (cnt_q == CNT_MAX);
   assign seq_done = qend && (qtr_q == 2'd3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_FREE;
         qtr_q       <= 2'd0;
         cnt_q       <= '0;
         slot_q      <= 4'd0;
         tx_q        <= 8'h00;
         rx_q        <= 8'h00;
         read_q      <= 1'b0;
         nack_q      <= 1'b0;
         busy_q      <= 1'b0;
         scl_q       <= 1'b1;
         sda_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_nack_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         qtr_q       <= qtr_d;
         cnt_q       <= cnt_d;
         slot_q      <= slot_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         read_q      <= read_d;
         nack_q      <= nack_d;
         busy_q      <= busy_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_nack_q  <= rsp_nack_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      qtr_d       = qtr_q;
      cnt_d       = cnt_q;
      slot_d      = slot_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      read_d      = read_q;
      nack_d      = nack_q;
      busy_d      = busy_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_nack_d  = rsp_nack_q;
      rsp_err_d   = rsp_err_q;
      scl_d       = scl_q;
      sda_d       = sda_q;

      case (state_q)
         ST_FREE, ST_HELD: begin
            if (accept) begin
               qtr_d = 2'd0;
               cnt_d = '0;
               case (cmd)
                  CMD_START: state_d = ST_START;
                  CMD_STOP:  state_d = (state_q == ST_HELD) ? ST_STOP : ST_WAIT;
                  CMD_WRITE, CMD_READ: begin
                     if (state_q == ST_HELD) begin
                        state_d = ST_BYTE;
                        slot_d  = 4'd0;
                        tx_d    = cmd_data;
                        rx_d    = 8'h00;
                        read_d  = (cmd == CMD_READ);
                        nack_d  = cmd_nack;
                     end else begin
                        // No bus owned: reject without touching the lines.
                        state_d     = ST_WAIT;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 8'h00;
                        rsp_nack_d  = 1'b1;
                     end
                  end
                  default: state_d = state_q;
               endcase
            end
         end

         ST_WAIT: state_d = ST_FREE;

         ST_START, ST_STOP, ST_BYTE: begin
            if (tick) begin
               cnt_d = qend ? '0 : cnt_q + 1'b1;
            end
            if (qend) begin
               qtr_d = qtr_q + 2'd1;
            end
            if (seq_done) begin
               if (state_q == ST_START) begin
                  state_d = ST_HELD;
                  busy_d  = 1'b1;
               end else if (state_q == ST_STOP) begin
                  state_d = ST_FREE;
                  busy_d  = 1'b0;
               end else if (slot_q == 4'd8) begin
                  state_d     = ST_HELD;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_data_d  = read_q ? rx_q : 8'h00;
                  rsp_nack_d  = read_q ? nack_q : sda_in;
               end else begin
                  slot_d = slot_q + 4'd1;
                  if (read_q) begin
                     rx_d = {rx_q[6:0], sda_in};
                  end else begin
                     tx_d = {tx_q[6:0], 1'b0};
                  end
               end
            end
         end

         default: state_d = ST_FREE;
      endcase

      // Line levels are decoded from the next state so the registered pins
      // line up exactly with the quarter they belong to.
      case (state_d)
         ST_HELD: begin
            scl_d = 1'b0;
            sda_d = sda_q;   // SDA only moves again at the next q0
         end
         ST_START: begin
            scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
            sda_d = (qtr_d == 2'd0) || (qtr_d == 2'd1);
         end
         ST_STOP: begin
            scl_d = (qtr_d != 2'd0);
            sda_d = qtr_d[1];
         end
         ST_BYTE: begin
            scl_d = qtr_d[1];
            if (slot_d == 4'd8) begin
               sda_d = read_d ? nack_d : 1'b1;
            end else begin
               sda_d = read_d ? 1'b1 : tx_d[7];
            end
         end
         default: begin
            scl_d = 1'b1;
            sda_d = 1'b1;
         end
      endcase
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_nack  = rsp_nack_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign scl_out   = scl_q;
   assign sda_out   = sda_q;

endmodule

// File: tb/tb_eeprom_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_eeprom_i2c_master
//   Directed bench for eeprom_i2c_master with CLK_DIV=4. The bus is modelled
//   as wired-AND of the DUT lines with a simple time-slotted slave.
// -----------------------------------------------------------------------------
module tb_eeprom_i2c_master;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd;
   logic [7:0] cmd_data;
   logic       cmd_nack;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_nack;
   logic       rsp_err;
   logic       busy;
   logic       scl_out;
   logic       sda_out;
   logic       scl_in;
   logic       sda_in;

   logic       slave_sda;
   logic       scl_hold_low;

   int         checks;
   int         errors;

   int         res_lat;
   int         res_viol;
   logic [8:0] res_sda;
   int         seq_fall;
   int         seq_rise;
   logic       busy15;
   logic       prev_scl;
   logic       prev_sda;

   assign scl_in = scl_out & ~scl_hold_low;
   assign sda_in = sda_out & slave_sda;

   eeprom_i2c_master #(.CLK_DIV(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .cmd_data  (cmd_data),
      .cmd_nack  (cmd_nack),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_nack  (rsp_nack),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .scl_out   (scl_out),
      .sda_out   (sda_out),
      .scl_in    (scl_in),
      .sda_in    (sda_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Called on a negedge; returns on the negedge of the first cycle after
   // acceptance (cycle 0).
   task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic nk);
      cmd       = c;
      cmd_data  = d;
      cmd_nack  = nk;
      cmd_valid = 1'b1;
      prev_scl  = scl_out;
      prev_sda  = sda_out;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // START/STOP: wait for cmd_ready, noting SDA edges while SCL is high.
   task automatic run_seq();
      res_lat  = -1;
      seq_fall = -1;
      seq_rise = -1;
      busy15   = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (prev_scl && scl_out && prev_sda && !sda_out) seq_fall = i;
         if (prev_scl && scl_out && !prev_sda && sda_out) seq_rise = i;
         if (i == 15) busy15 = busy;
         if (cmd_ready) begin
            res_lat = i;
            break;
         end
         prev_scl = scl_out;
         prev_sda = sda_out;
         @(negedge clk);
      end
      if (res_lat < 0) check_val("seq_timeout", {31'd0, cmd_ready}, 32'd1);
   endtask

   // Byte transfer. slave_bits[8-k] is what the slave puts on SDA in slot k
   // (16 cycles per slot without stretching). SCL is held low for 20 cycles
   // from cycle stretch_at when stretch_at >= 0.
   task automatic run_byte(input logic [8:0] slave_bits, input int stretch_at);
      res_lat  = -1;
      res_viol = 0;
      res_sda  = '1;
      for (int i = 0; i < 600; i++) begin
         if (prev_scl && scl_out && (prev_sda != sda_out)) res_viol++;
         if ((i % 16 == 8) && (i < 144)) res_sda[8 - i / 16] = sda_out;
         if (rsp_valid) begin
            res_lat = i;
            break;
         end
         prev_scl     = scl_out;
         prev_sda     = sda_out;
         slave_sda    = (i / 16 < 9) ? slave_bits[8 - i / 16] : 1'b1;
         scl_hold_low = (stretch_at >= 0) && (i >= stretch_at) && (i < stretch_at + 20);
         @(negedge clk);
      end
      slave_sda    = 1'b1;
      scl_hold_low = 1'b0;
      if (res_lat < 0) check_val("byte_timeout", {31'd0, rsp_valid}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b0;
      cmd_valid    = 1'b0;
      cmd          = 2'b00;
      cmd_data     = 8'h00;
      cmd_nack     = 1'b0;
      slave_sda    = 1'b1;
      scl_hold_low = 1'b0;
      prev_scl     = 1'b1;
      prev_sda     = 1'b1;

      repeat (3) @(negedge clk);
      check_val("rst_scl",       {31'd0, scl_out},   32'd1);
      check_val("rst_sda",       {31'd0, sda_out},   32'd1);
      check_val("rst_ready",     {31'd0, cmd_ready}, 32'd1);
      check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_val("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
      check_val("rst_rsp_flags", {30'd0, rsp_nack, rsp_err}, 32'd0);
      check_val("rst_busy",      {31'd0, busy},      32'd0);
      reset = 1'b1;
      @(negedge clk);

      // START from FREE
      issue(2'b00, 8'h00, 1'b0);
      run_seq();
      check_val("start_cycles", res_lat, 16);
      check_val("start_sda_fall_at", seq_fall, 8);
      check_val("start_busy", {31'd0, busy}, 32'd1);
      check_val("start_lines", {30'd0, scl_out, sda_out}, 32'd0);

      // WRITE 0xA0, slave acks
      issue(2'b10, 8'hA0, 1'b0);
      run_byte(9'h1FE, -1);
      check_val("wr_a0_latency", res_lat, 144);
      check_val("wr_a0_sda_slots", {23'd0, res_sda}, 32'h141);
      check_val("wr_a0_nack", {31'd0, rsp_nack}, 32'd0);
      check_val("wr_a0_data", {24'd0, rsp_data}, 32'd0);
      check_val("wr_a0_err", {31'd0, rsp_err}, 32'd0);
      check_val("wr_a0_sda_stable", res_viol, 0);
      @(negedge clk);
      check_val("wr_a0_pulse_end", {31'd0, rsp_valid}, 32'd0);

      // WRITE 0x3C, no slave present
      issue(2'b10, 8'h3C, 1'b0);
      run_byte(9'h1FF, -1);
      check_val("wr_3c_latency", res_lat, 144);
      check_val("wr_3c_sda_slots", {23'd0, res_sda}, 32'h079);
      check_val("wr_3c_nack", {31'd0, rsp_nack}, 32'd1);
      check_val("wr_3c_busy_ready", {30'd0, busy, cmd_ready}, 32'd3);
      check_val("wr_3c_scl_low", {31'd0, scl_out}, 32'd0);

      // READ 0x5C with master NACK
      issue(2'b11, 8'h00, 1'b1);
      run_byte(9'h0B9, -1);
      check_val("rd_5c_data", {24'd0, rsp_data}, 32'h5C);
      check_val("rd_5c_nack", {31'd0, rsp_nack}, 32'd1);
      check_val("rd_5c_sda_slots", {23'd0, res_sda}, 32'h1FF);
      check_val("rd_5c_err", {31'd0, rsp_err}, 32'd0);

      // READ 0xA3 with master ACK
      issue(2'b11, 8'h00, 1'b0);
      run_byte(9'h147, -1);
      check_val("rd_a3_data", {24'd0, rsp_data}, 32'hA3);
      check_val("rd_a3_nack", {31'd0, rsp_nack}, 32'd0);
      check_val("rd_a3_sda_slots", {23'd0, res_sda}, 32'h1FE);
      check_val("rd_a3_sda_stable", res_viol, 0);

      // Repeated START from HELD
      issue(2'b00, 8'h00, 1'b0);
      run_seq();
      check_val("rstart_cycles", res_lat, 16);
      check_val("rstart_sda_fall_at", seq_fall, 8);
      check_val("rstart_busy", {31'd0, busy}, 32'd1);

      // STOP
      issue(2'b01, 8'h00, 1'b0);
      run_seq();
      check_val("stop_cycles", res_lat, 16);
      check_val("stop_sda_rise_at", seq_rise, 8);
      check_val("stop_busy_q3", {31'd0, busy15}, 32'd1);
      check_val("stop_busy_after", {31'd0, busy}, 32'd0);
      check_val("stop_lines", {30'd0, scl_out, sda_out}, 32'd3);

      // WRITE in FREE: error response, no bus activity
      issue(2'b10, 8'hFF, 1'b0);
      check_val("free_wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("free_wr_err_nack", {30'd0, rsp_err, rsp_nack}, 32'd3);
      check_val("free_wr_data", {24'd0, rsp_data}, 32'd0);
      check_val("free_wr_ready_low", {31'd0, cmd_ready}, 32'd0);
      check_val("free_wr_lines0", {30'd0, scl_out, sda_out}, 32'd3);
      @(negedge clk);
      check_val("free_wr_ready_back", {31'd0, cmd_ready}, 32'd1);
      check_val("free_wr_pulse_end", {31'd0, rsp_valid}, 32'd0);
      check_val("free_wr_lines1", {30'd0, scl_out, sda_out}, 32'd3);

      // STOP in FREE: no response, ready back after one cycle
      issue(2'b01, 8'h00, 1'b0);
      check_val("free_stop_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check_val("free_stop_ready_low", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check_val("free_stop_ready_back", {31'd0, cmd_ready}, 32'd1);
      check_val("free_stop_lines", {30'd0, scl_out, sda_out, busy}, 32'd6);

      // Clock stretching: SCL held low 20 cycles from slot 3 q2
      issue(2'b00, 8'h00, 1'b0);
      run_seq();
      issue(2'b10, 8'h55, 1'b0);
      run_byte(9'h1FF, 56);
      check_val("stretch_latency", res_lat, 164);
      check_val("stretch_err_cleared", {31'd0, rsp_err}, 32'd0);
      check_val("stretch_nack", {31'd0, rsp_nack}, 32'd1);

      // Reset in the middle of a byte
      issue(2'b10, 8'h00, 1'b0);
      repeat (50) @(negedge clk);
      check_val("midbyte_lines", {30'd0, scl_out, sda_out}, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      check_val("async_rst_lines", {30'd0, scl_out, sda_out}, 32'd3);
      check_val("async_rst_busy", {31'd0, busy}, 32'd0);
      check_val("async_rst_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("async_rst_rsp", {22'd0, rsp_valid, rsp_data, rsp_nack, rsp_err}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
